// File: rtl/lcd_bus_scheduler.sv
// lcd_bus_scheduler
//
// Serialises byte writes from two requester engines onto the shared LCD1602
// 8-bit write bus. Requests are granted round-robin. Each granted byte gets
// a complete RS/RW/E/DATA write cycle: setup, enable-high, hold, then an
// execution wait that is long for Clear Display / Return Home and short
// for every other write.
//
// Ports:
//   clk              system clock
//   reset            asynchronous, active-low reset
//   req0/rs0/data0   requester 0 (init/CGRAM engine): request, RS, byte
//   ack0             one-cycle pulse when requester 0's byte is accepted
//   req1/rs1/data1   requester 1 (text/display engine): request, RS, byte
//   ack1             one-cycle pulse when requester 1's byte is accepted
//   busy             high whenever the scheduler is not idle
//   lcd_rs           LCD register select
//   lcd_rw           LCD read/write, always 0 (write-only bus)
//   lcd_enable       LCD enable strobe
//   lcd_data         LCD DB7..DB0
//
// Every timing parameter must be at least 1.
module lcd_bus_scheduler #(
  parameter int T_POWERUP    = 2500000,
  parameter int T_SETUP      = 2,
  parameter int T_EN         = 25,
  parameter int T_HOLD       = 2,
  parameter int T_WAIT_SHORT = 2500,
  parameter int T_WAIT_LONG  = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       rs0,
  input  logic [7:0] data0,
  output logic       ack0,
  input  logic       req1,
  input  logic       rs1,
  input  logic [7:0] data1,
  output logic       ack1,
  output logic       busy,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_enable,
  output logic [7:0] lcd_data
);

  // One shared counter covers every timed state, so it is sized by the
  // largest duration.
  localparam int MAX_A = (T_POWERUP > T_WAIT_LONG) ? T_POWERUP : T_WAIT_LONG;
  localparam int MAX_B = (T_SETUP > T_EN) ? T_SETUP : T_EN;
  localparam int MAX_C = (T_HOLD > T_WAIT_SHORT) ? T_HOLD : T_WAIT_SHORT;
  localparam int MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int MAX_T = (MAX_C > MAX_D) ? MAX_C : MAX_D;
  localparam int CNT_W = $clog2(MAX_T) + 1;

  localparam logic [2:0] ST_POWERUP = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;
  localparam logic [2:0] ST_SETUP   = 3'd2;
  localparam logic [2:0] ST_EN      = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;
  localparam logic [2:0] ST_WAIT    = 3'd5;

  logic [2:0]       state_reg;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] counter_reg;
  logic [CNT_W-1:0] counter_next;
  logic             last_grant_reg;

  logic [CNT_W-1:0] last_count;
  logic [2:0]       timed_next;
  logic             long_wait;
  logic             any_req;
  logic             grant_valid;
  logic             grant_port;
  logic [1:0]       ack_next;
  logic             rs_sel;
  logic [7:0]       data_sel;

  // Clear Display (0x01) and Return Home (0x02/0x03) are the only slow
  // instructions. The latched byte is stable for the whole write, so it can
  // be decoded directly while in WAIT.
  assign long_wait = !lcd_rs && ((lcd_data == 8'h01) || (lcd_data == 8'h02) ||
                                 (lcd_data == 8'h03));

  // Round-robin: on contention the port that did not win last time wins.
  assign any_req    = req0 | req1;
  assign grant_port = (req0 & req1) ? ~last_grant_reg : req1;
  assign rs_sel     = grant_port ? rs1 : rs0;
  assign data_sel   = grant_port ? data1 : data0;

  // Per-port acknowledge: only the granted port sees its pulse.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
      assign ack_next[gi] = grant_valid && (grant_port == 1'(gi));
    end
  endgenerate

  // Terminal count and successor for each timed state.
  always_comb begin
    last_count = '0;
    timed_next = ST_IDLE;
    case (state_reg)
      ST_POWERUP: begin
        last_count = CNT_W'(T_POWERUP - 1);
        timed_next = ST_IDLE;
      end
      ST_SETUP: begin
        last_count = CNT_W'(T_SETUP - 1);
        timed_next = ST_EN;
      end
      ST_EN: begin
        last_count = CNT_W'(T_EN - 1);
        timed_next = ST_HOLD;
      end
      ST_HOLD: begin
        last_count = CNT_W'(T_HOLD - 1);
        timed_next = ST_WAIT;
      end
      ST_WAIT: begin
        last_count = long_wait ? CNT_W'(T_WAIT_LONG - 1) : CNT_W'(T_WAIT_SHORT - 1);
        timed_next = ST_IDLE;
      end
      default: begin
        last_count = '0;
        timed_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    counter_next = counter_reg;
    grant_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Requests are only looked at here; outside IDLE they simply wait.
        if (any_req) begin
          grant_valid  = 1'b1;
          state_next   = ST_SETUP;
          counter_next = '0;
        end
      end
      ST_POWERUP, ST_SETUP, ST_EN, ST_HOLD, ST_WAIT: begin
        if (counter_reg == last_count) begin
          state_next   = timed_next;
          counter_next = '0;
        end else begin
          counter_next = counter_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next   = ST_POWERUP;
        counter_next = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state value so E and busy line up
  // exactly with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_POWERUP;
      counter_reg    <= '0;
      last_grant_reg <= 1'b1;
      ack0           <= 1'b0;
      ack1           <= 1'b0;
      busy           <= 1'b1;
      lcd_rs         <= 1'b0;
      lcd_rw         <= 1'b0;
      lcd_enable     <= 1'b0;
      lcd_data       <= 8'h00;
    end else begin
      state_reg   <= state_next;
      counter_reg <= counter_next;
      ack0        <= ack_next[0];
      ack1        <= ack_next[1];
      busy        <= (state_next != ST_IDLE);
      lcd_rw      <= 1'b0;
      lcd_enable  <= (state_next == ST_EN);
      if (grant_valid) begin
        last_grant_reg <= grant_port;
        lcd_rs         <= rs_sel;
        lcd_data       <= data_sel;
      end
    end
  end

endmodule

// File: doc/lcd_bus_scheduler.md
Name: lcd_bus_scheduler

Overview:
Sequences all accesses to the shared LCD1602 8-bit write bus. Two requester engines present one byte at a time with a request/acknowledge handshake: port 0 is the init/CGRAM custom-character engine, port 1 is the text/display-update engine. The scheduler arbitrates round-robin and produces the RS/RW/E/DATA waveform with programmable setup, enable-high, hold and execution-wait times. It replaces the free-running enable divider, so the LCD is written at bus speed rather than one byte per 16 ms tick.

Parameters:
T_POWERUP, 2500000, cycles held busy after reset before the first grant (50 ms at 50 MHz)
T_SETUP, 2, cycles RS/DATA are stable before E rises
T_EN, 25, cycles E is high
T_HOLD, 2, cycles RS/DATA are held after E falls
T_WAIT_SHORT, 2500, execution wait after a normal command or data write (50 us)
T_WAIT_LONG, 100000, execution wait after Clear Display or Return Home (2 ms)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
req0  in  1  requester 0 has a byte pending; hold until ack0
rs0  in  1  requester 0 register select (0 = command, 1 = data)
data0  in  8  requester 0 byte
ack0  out  1  one-cycle pulse: requester 0 byte accepted
req1, rs1, data1, ack1  same as above, for requester 1
busy  out  1  high whenever the state is not IDLE
lcd_rs  out  1  LCD RS
lcd_rw  out  1  LCD RW; tied to 0 (write-only)
lcd_enable  out  1  LCD E
lcd_data  out  8  LCD DB7..DB0

Behaviour:
- Reset (async, reset==0) forces: state=POWERUP, counter=0, lcd_rs=0, lcd_rw=0, lcd_enable=0, lcd_data=0x00, ack0=ack1=0, last_grant=1. A reset mid-transfer drops E immediately and restarts from POWERUP.
- All outputs are registered. Only one ack is high in any cycle.
- State machine:
  - POWERUP: counts T_POWERUP cycles, then goes to IDLE.
  - IDLE: grant decision.
    - Only one req high: that port is granted.
    - Both high: the port != last_grant is granted.
    - Neither high: stay in IDLE.
    - On the grant edge: latch rs/data into lcd_rs/lcd_data, set last_grant, assert ackN for the next single cycle, go to SETUP.
  - SETUP: T_SETUP cycles with E=0, then EN.
  - EN: T_EN cycles with E=1, then HOLD.
  - HOLD: T_HOLD cycles with E=0 and rs/data unchanged, then WAIT.
  - WAIT: runs T_WAIT_LONG cycles if the latched rs=0 and data is 0x01, 0x02 or 0x03; otherwise T_WAIT_SHORT cycles. Then IDLE.
- Each timed state lasts exactly its parameter count, which must be ≥1. The counter width is $clog2 of the largest parameter, plus 1.
- Handshake:
  - A requester keeps req/rs/data stable while req=1 and its ack=0.
  - On the cycle ack=1, the requester may change data or drop req.
  - req is ignored outside IDLE.
  - Dropping req before ack withdraws the request with no effect.
- Back-to-back throughput: the earliest next grant is the first IDLE cycle. Period = 1 + T_SETUP + T_EN + T_HOLD + T_WAIT.
- lcd_rs/lcd_data keep their last value while in IDLE.

Test Plan:
Bench parameters: T_POWERUP=5, T_SETUP=1, T_EN=2, T_HOLD=1, T_WAIT_SHORT=4, T_WAIT_LONG=10.
1. Release reset with req0=1, rs0=0, data0=0x38 -> busy=1 for 5 cycles, no ack. Grant on the first IDLE cycle, ack0 pulses once. lcd_data=0x38, lcd_rs=0, E high for exactly 2 cycles. busy low again 8 cycles after the grant edge.
2. req0 (0x01, rs=0), then later req0 (0x41, rs=1) -> the 0x01 write occupies 14 cycles after grant (long wait). The 0x41 write occupies 8 cycles (short wait).
3. req0 and req1 both held continuously -> grants alternate 0,1,0,1, with 0 first after reset. Ack pulses are spaced exactly 9 cycles apart.
4. req1 asserted during SETUP of a req0 transfer -> no ack1 until the next IDLE. ack1 arrives on the first IDLE cycle; lcd_data is unchanged during the whole EN/HOLD window.
5. Assert reset while E=1 -> lcd_enable, lcd_data and acks go to 0 in the same cycle (async). After release, POWERUP repeats 5 cycles before any grant.
6. Drop req0 before ack, with no other requests -> no ack, no E pulse, state stays IDLE; lcd_rw=0 throughout all scenarios.
